// File: rtl/cla_bist_pkg.sv
// Shared types and constants for the CLA adder built-in self-test.
package cla_bist_pkg;

  localparam int CLA_BIST_WIDTH    = 16;
  localparam int CLA_BIST_SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } cla_bist_state_e;

endpackage

// File: rtl/cla_bist_vec_gen.sv
// Operand counter chain for the BIST sweep: A counts fastest, then B, then C_In.
module cla_bist_vec_gen
  import cla_bist_pkg::*;
#(
  parameter int WIDTH = CLA_BIST_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] vec_a,
  output logic [WIDTH-1:0] vec_b,
  output logic             vec_cin,
  output logic             last_vec
);

  logic a_wrap;
  logic b_wrap;

  assign a_wrap   = &vec_a;
  assign b_wrap   = &vec_b;
  assign last_vec = a_wrap & b_wrap & vec_cin;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vec_a   <= '0;
      vec_b   <= '0;
      vec_cin <= 1'b0;
    end else if (advance) begin
      vec_a <= vec_a + WIDTH'(1);
      if (a_wrap) begin
        vec_b <= vec_b + WIDTH'(1);
        if (b_wrap) begin
          vec_cin <= ~vec_cin;
        end
      end
    end
  end

endmodule

// File: rtl/cla_adder_bist.sv
// Exhaustive on-chip BIST driver/checker for the WIDTH-bit CLA adder.
// Optional CLA_BIST_STOP_ON_ERR_EN adds stop_on_err to end the sweep at the first mismatch.
module cla_adder_bist
  import cla_bist_pkg::*;
#(
  parameter int WIDTH         = CLA_BIST_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef CLA_BIST_STOP_ON_ERR_EN
  input  logic             stop_on_err,
`endif
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin
);

  cla_bist_state_e             state;
  logic [CLA_BIST_SETTLE_W-1:0] settle_cnt;
  logic                        vec_clear;
  logic                        vec_advance;
  logic                        last_vec;
  logic                        stop_en;
  logic                        mismatch;
  logic                        finish_sweep;
  logic [WIDTH:0]              expected;
  logic [ERR_W-1:0]            err_next;

`ifdef CLA_BIST_STOP_ON_ERR_EN
  assign stop_en = stop_on_err;
`else
  assign stop_en = 1'b0;
`endif

  // Reference is kept at WIDTH+1 bits so a dropped carry is always caught.
  always_comb begin
    expected = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    mismatch = ({dut_cout, dut_sum} != expected);
    err_next = err_count;
    if (mismatch && !(&err_count)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  assign finish_sweep = last_vec || (mismatch && stop_en);
  assign vec_clear    = ((state == IDLE) || (state == DONE)) && start;
  assign vec_advance  = (state == CHECK) && !finish_sweep;

  cla_bist_vec_gen #(
    .WIDTH(WIDTH)
  ) u_vec_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (vec_clear),
    .advance (vec_advance),
    .vec_a   (dut_a),
    .vec_b   (dut_b),
    .vec_cin (dut_cin),
    .last_vec(last_vec)
  );

  // state  | meaning
  // IDLE   | waiting for start after reset
  // SETTLE | operands stable, waiting SETTLE_CYCLES for the adder
  // CHECK  | compare result, record errors, advance or finish
  // DONE   | results valid until next start
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= SETTLE;
            settle_cnt      <= CLA_BIST_SETTLE_W'(SETTLE_CYCLES);
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
          end
        end

        SETTLE: begin
          if (settle_cnt <= CLA_BIST_SETTLE_W'(1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - CLA_BIST_SETTLE_W'(1);
          end
        end

        CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_a     <= dut_a;
            first_err_b     <= dut_b;
            first_err_cin   <= dut_cin;
          end
          if (finish_sweep) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state      <= SETTLE;
            settle_cnt <= CLA_BIST_SETTLE_W'(SETTLE_CYCLES);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
